// File: rtl/block_sync_if.sv
// Block-sync bus: 66-bit block input side and aligned payload/status output side.
// master = block source and payload consumer, slave = block_sync.
interface block_sync_if;
  logic        ena;
  logic [65:0] din;
  logic        slip;
  logic        block_lock;
  logic [63:0] dout;
  logic [1:0]  hdr;
  logic        dout_valid;
  logic [15:0] sh_err_cnt;

  modport master (
    output ena, din,
    input  slip, block_lock, dout, hdr, dout_valid, sh_err_cnt
  );

  modport slave (
    input  ena, din,
    output slip, block_lock, dout, hdr, dout_valid, sh_err_cnt
  );
endinterface

// File: rtl/block_sync.sv
// 64b/66b block synchroniser: hunts for sync-header alignment by slipping the gearbox,
// declares lock after LOCK_CNT good headers and monitors windows for header errors.
module block_sync #(
  parameter int LOCK_CNT  = 64,
  parameter int INVLD_MAX = 16,
  parameter int SLIP_WAIT = 4
) (
  input  logic         clk,
  input  logic         arst,
  block_sync_if.slave  bus
);

  localparam int SHW = $clog2(LOCK_CNT + 1);
  localparam int IVW = $clog2(INVLD_MAX + 1);
  localparam int HDW = $clog2(SLIP_WAIT + 1);

  typedef enum logic [1:0] {
    HUNT      = 2'd0,
    SLIP_HOLD = 2'd1,
    LOCKED    = 2'd2
  } state_t;

  state_t         state, state_nxt;
  logic [SHW-1:0] sh_cnt, sh_nxt, sh_inc;
  logic [IVW-1:0] invld_cnt, invld_nxt, invld_inc;
  logic [HDW-1:0] hold_cnt, hold_nxt, hold_inc;
  logic [15:0]    err_cnt, err_nxt;
  logic           slip_q, slip_nxt;
  logic [63:0]    dout_q;
  logic [1:0]     hdr_q;
  logic           vld_q;
  logic           hdr_ok;

  // 01 and 10 are the only legal headers: exactly one bit set
  assign hdr_ok    = bus.din[0] ^ bus.din[1];
  assign sh_inc    = sh_cnt + SHW'(1);
  assign invld_inc = invld_cnt + IVW'(1);
  assign hold_inc  = hold_cnt + HDW'(1);

  always_comb begin
    state_nxt = state;
    sh_nxt    = sh_cnt;
    invld_nxt = invld_cnt;
    hold_nxt  = hold_cnt;
    err_nxt   = err_cnt;
    slip_nxt  = 1'b0;
    if (bus.ena) begin
      unique case (state)
        HUNT: begin
          if (hdr_ok) begin
            sh_nxt = sh_inc;
            if (sh_inc == SHW'(LOCK_CNT)) begin
              state_nxt = LOCKED;
              sh_nxt    = '0;
              invld_nxt = '0;
            end
          end else begin
            slip_nxt  = 1'b1;
            sh_nxt    = '0;
            hold_nxt  = '0;
            state_nxt = SLIP_HOLD;
          end
        end
        SLIP_HOLD: begin
          // blocks here are still misaligned by the pending shift, so they are not inspected
          hold_nxt = hold_inc;
          if (hold_inc == HDW'(SLIP_WAIT)) begin
            hold_nxt  = '0;
            sh_nxt    = '0;
            state_nxt = HUNT;
          end
        end
        LOCKED: begin
          sh_nxt = sh_inc;
          if (!hdr_ok) begin
            invld_nxt = invld_inc;
            if (err_cnt != 16'hFFFF) err_nxt = err_cnt + 16'd1;
          end
          // loss of lock wins over a window end on the same block
          if (!hdr_ok && invld_inc == IVW'(INVLD_MAX)) begin
            slip_nxt  = 1'b1;
            sh_nxt    = '0;
            invld_nxt = '0;
            hold_nxt  = '0;
            state_nxt = SLIP_HOLD;
          end else if (sh_inc == SHW'(LOCK_CNT)) begin
            sh_nxt    = '0;
            invld_nxt = '0;
          end
        end
        default: begin
          state_nxt = HUNT;
          sh_nxt    = '0;
          invld_nxt = '0;
          hold_nxt  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      state     <= HUNT;
      sh_cnt    <= '0;
      invld_cnt <= '0;
      hold_cnt  <= '0;
      err_cnt   <= '0;
      slip_q    <= 1'b0;
      dout_q    <= '0;
      hdr_q     <= '0;
      vld_q     <= 1'b0;
    end else begin
      state     <= state_nxt;
      sh_cnt    <= sh_nxt;
      invld_cnt <= invld_nxt;
      hold_cnt  <= hold_nxt;
      err_cnt   <= err_nxt;
      slip_q    <= slip_nxt;
      // validity follows the state the block was received in, not the updated one
      vld_q     <= bus.ena && (state == LOCKED);
      if (bus.ena) begin
        dout_q <= bus.din[65:2];
        hdr_q  <= bus.din[1:0];
      end
    end
  end

  assign bus.slip       = slip_q;
  assign bus.block_lock = (state == LOCKED);
  assign bus.dout       = dout_q;
  assign bus.hdr        = hdr_q;
  assign bus.dout_valid = vld_q;
  assign bus.sh_err_cnt = err_cnt;

endmodule

// File: tb/tb_block_sync.sv
// Self-checking bench for block_sync: cycle model for lock/slip/error status plus a
// scoreboard of payloads that must appear on dout with dout_valid.
module tb_block_sync;
  localparam int LOCK = 64;
  localparam int INV  = 16;
  localparam int SW   = 4;

  logic clk = 1'b0;
  logic arst;
  always #5 clk = ~clk;

  block_sync_if bus();

  block_sync #(.LOCK_CNT(LOCK), .INVLD_MAX(INV), .SLIP_WAIT(SW)) dut (
    .clk  (clk),
    .arst (arst),
    .bus  (bus)
  );

  int n_chk = 0;
  int n_err = 0;
  logic [65:0] sb[$];

  // reference model: 0 hunt, 1 slip hold, 2 locked
  int m_st, m_sh, m_inv, m_hold, m_err;
  logic [63:0] m_dout;
  logic [1:0]  m_hdr;

  task automatic chk(input string tag, input logic [65:0] act, input logic [65:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%h want=%h", tag, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic [1:0] h);
    logic [65:0] d;
    logic [65:0] q;
    logic ev, es, good;
    d    = {$urandom(), $urandom(), h};
    good = (h == 2'b01) || (h == 2'b10);
    arst = r;
    bus.ena = e;
    bus.din = d;
    ev = 1'b0;
    es = 1'b0;
    if (r) begin
      m_st = 0; m_sh = 0; m_inv = 0; m_hold = 0; m_err = 0;
      m_dout = '0; m_hdr = '0;
    end else if (e) begin
      ev = (m_st == 2);
      m_dout = d[65:2];
      m_hdr  = h;
      if (ev) sb.push_back(d);
      case (m_st)
        0: begin
          if (good) begin
            m_sh++;
            if (m_sh == LOCK) begin m_st = 2; m_sh = 0; m_inv = 0; end
          end else begin
            es = 1'b1; m_sh = 0; m_hold = 0; m_st = 1;
          end
        end
        1: begin
          m_hold++;
          if (m_hold == SW) begin m_st = 0; m_hold = 0; m_sh = 0; end
        end
        default: begin
          m_sh++;
          if (!good) begin
            m_inv++;
            if (m_err < 65535) m_err++;
          end
          if (m_inv == INV) begin
            es = 1'b1; m_st = 1; m_sh = 0; m_inv = 0; m_hold = 0;
          end else if (m_sh == LOCK) begin
            m_sh = 0; m_inv = 0;
          end
        end
      endcase
    end
    @(posedge clk);
    #1;
    chk("lock", bus.block_lock, (m_st == 2));
    chk("slip", bus.slip, es);
    chk("err_cnt", bus.sh_err_cnt, m_err);
    chk("dout_valid", bus.dout_valid, ev);
    chk("dout_hold", bus.dout, m_dout);
    chk("hdr_hold", bus.hdr, m_hdr);
    if (bus.dout_valid) begin
      if (sb.size() == 0) chk("sb_underrun", sb.size(), 1);
      else begin
        q = sb.pop_front();
        chk("sb_data", {bus.dout, bus.hdr}, q);
      end
    end
  endtask

  initial begin
    int clks;
    arst = 1'b1;
    bus.ena = 1'b0;
    bus.din = '0;
    m_st = 0; m_sh = 0; m_inv = 0; m_hold = 0; m_err = 0;
    m_dout = '0; m_hdr = '0;

    // reset state, and an invalid block sampled under reset must not slip
    step(1'b1, 1'b0, 2'b00);
    step(1'b1, 1'b1, 2'b11);
    chk("rst_lock", bus.block_lock, 1'b0);
    chk("rst_slip", bus.slip, 1'b0);
    chk("rst_dout", {bus.dout, bus.hdr}, 66'd0);

    // lock acquisition: 64 data headers
    repeat (63) step(1'b0, 1'b1, 2'b01);
    chk("acq_lock63", bus.block_lock, 1'b0);
    step(1'b0, 1'b1, 2'b01);
    chk("acq_lock64", bus.block_lock, 1'b1);
    chk("acq_dv64", bus.dout_valid, 1'b0);
    step(1'b0, 1'b1, 2'b10);
    chk("acq_dv65", bus.dout_valid, 1'b1);

    // hunt slip: 10 good, one bad, 4 ignored bad blocks, then fresh 64
    step(1'b1, 1'b0, 2'b00);
    repeat (10) step(1'b0, 1'b1, 2'b01);
    step(1'b0, 1'b1, 2'b11);
    chk("hunt_slip", bus.slip, 1'b1);
    repeat (4) step(1'b0, 1'b1, 2'b00);
    chk("hold_noslip", bus.slip, 1'b0);
    repeat (63) step(1'b0, 1'b1, 2'b10);
    chk("relock63", bus.block_lock, 1'b0);
    step(1'b0, 1'b1, 2'b01);
    chk("relock64", bus.block_lock, 1'b1);

    // 15 scattered errors in one window survive; 16 in the next lose lock
    for (int i = 0; i < 64; i++)
      step(1'b0, 1'b1, ((i % 4 == 1) && (i < 60)) ? ((i % 8 == 1) ? 2'b00 : 2'b11) : 2'b01);
    chk("win15_lock", bus.block_lock, 1'b1);
    chk("win15_err", bus.sh_err_cnt, 16'd15);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, (i % 2 == 0) ? 2'b11 : 2'b00);
    chk("win16_slip", bus.slip, 1'b1);
    chk("win16_lock", bus.block_lock, 1'b0);

    // 16th error lands on the window's last block
    repeat (4) step(1'b0, 1'b1, 2'b01);
    repeat (64) step(1'b0, 1'b1, 2'b01);
    chk("edge_locked", bus.block_lock, 1'b1);
    for (int i = 0; i < 63; i++) step(1'b0, 1'b1, (i < 15) ? 2'b00 : 2'b10);
    chk("edge_lock63", bus.block_lock, 1'b1);
    step(1'b0, 1'b1, 2'b11);
    chk("edge_slip", bus.slip, 1'b1);
    chk("edge_lock", bus.block_lock, 1'b0);
    chk("edge_dv", bus.dout_valid, 1'b1);
    chk("edge_err", bus.sh_err_cnt, 16'd47);

    // ena toggling: idle cycles carry bad headers that must be ignored
    step(1'b1, 1'b0, 2'b00);
    clks = 0;
    for (int i = 0; i < 64; i++) begin
      if (i == 63) chk("tog_lock126", bus.block_lock, 1'b0);
      step(1'b0, 1'b1, 2'b01);
      clks++;
      if (i < 63) begin
        step(1'b0, 1'b0, 2'b11);
        clks++;
      end
    end
    chk("tog_lock", bus.block_lock, 1'b1);
    chk("tog_clks", clks, 127);

    // reset while locked with errors
    repeat (5) step(1'b0, 1'b1, 2'b00);
    chk("err5", bus.sh_err_cnt, 16'd5);
    step(1'b1, 1'b1, 2'b11);
    chk("arst_lock", bus.block_lock, 1'b0);
    chk("arst_err", bus.sh_err_cnt, 16'd0);
    chk("arst_dv", bus.dout_valid, 1'b0);

    // reset landing on the slip pulse cycle
    step(1'b0, 1'b1, 2'b00);
    chk("pre_slip", bus.slip, 1'b1);
    step(1'b1, 1'b1, 2'b00);
    chk("arst_slip", bus.slip, 1'b0);
    repeat (64) step(1'b0, 1'b1, 2'b10);
    chk("post_rst_lock", bus.block_lock, 1'b1);
    repeat (3) step(1'b0, 1'b1, 2'b01);

    chk("sb_left", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
